ram_wr_post_buf: RTL
====================

Name: ram_wr_post_buf

Overview:
- Write-posting front end that sits directly upstream of the dual-port RAM, on the same clock.
- Accepts host writes into a small FIFO and drains them to the RAM write port whenever the port is granted.
- Issues host reads straight to the RAM read port.
- Keeps read-after-write ordering through forwarding, or through read stalls when forwarding is compiled out.

Parameters:
- DATA_WIDTH, 64, data bus width.
- ADDR_WIDTH, 12, RAM address width.
- DEPTH, 4, posted-write entries; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_wr_valid  in  1  host write request.
- in_wr_ready  out  1  buffer can accept a write.
- in_wr_addr  in  ADDR_WIDTH  host write address.
- in_wr_data  in  DATA_WIDTH  host write data.
- in_rd_req  in  1  host read request.
- in_rd_ready  out  1  read accepted this cycle.
- in_rd_addr  in  ADDR_WIDTH  host read address.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_WIDTH  read data.
- flush_req  in  1  pulse: drain all posted writes.
- flush_done  out  1  one-cycle pulse when the flush completes.
- ram_we  out  1  RAM write enable.
- ram_wr_gnt  in  1  RAM write port available this cycle.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after ram_re.
- buf_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- **Reset:** asserting rst immediately clears everything.
  - Outputs: in_wr_ready=1, in_rd_ready=1, rd_valid=0, rd_data=0, flush_done=0, ram_we=0, ram_re=0, buf_count=0, addresses and data 0.
  - FSM goes to NORMAL.
  - Posted writes are discarded; reset mid-operation loses them by design.
- **Push:** a write is pushed when in_wr_valid && in_wr_ready. in_wr_ready = (count<DEPTH) && state==NORMAL.
- **Drain:** ram_we = (count>0) && ram_wr_gnt, combinational.
  - ram_waddr/ram_wdata always present the head entry.
  - The head pops at the clock edge when ram_we is high.
- **Simultaneous push and pop:** count is unchanged. When full and popping in the same cycle, in_wr_ready stays 0 (no same-cycle reuse).
- **Pointers:** rd_ptr and wr_ptr wrap modulo DEPTH.
- **Read issue:** when in_rd_req && in_rd_ready, ram_re=1 and ram_raddr=in_rd_addr, combinational.
  - rd_valid is asserted exactly 1 cycle later.
  - rd_data is registered into the same cycle as rd_valid.
- **RAM semantics:** the RAM is read-old. A same-cycle RAM write to the read address is not visible. Because of this, the buffer search includes the head entry even while it is popping.
- **Same-cycle host write and read to one address:** the incoming write is NOT visible; the read returns the prior value (buffered or RAM).
- **FSM:**
  - NORMAL: flush_req → FLUSH.
  - FLUSH: in_wr_ready=0; drain continues; when count==0 (including the cycle of the last pop) → DONE.
  - DONE: flush_done=1 for one cycle → NORMAL.
  - flush_req while in FLUSH or DONE is ignored.
  - flush_req with an empty buffer gives NORMAL→FLUSH→DONE, so flush_done comes 2 cycles after the request.
- **Reads during flush:** reads are allowed in every state.

Optional Feature:
RAM_WR_FWD_EN.
- **Defined:**
  - in_rd_ready is always 1.
  - On read accept, all valid entries are compared with in_rd_addr.
  - On a hit, the youngest matching entry's data is captured and returned as rd_data instead of ram_rdata.
  - On a miss, ram_rdata is returned.
- **Undefined:**
  - in_rd_ready = 0 while any valid entry matches in_rd_addr, so the read stalls until the match drains.
  - ram_re is suppressed while stalled.
  - rd_data always comes from ram_rdata.

Decomposition:
- **Package ram_buf_pkg:**
  - enum ram_buf_state_e {NORMAL, FLUSH, DONE}.
  - Struct ram_buf_entry_t {addr, data}.
  - Localparam for the count width.
- **Sub-module ram_buf_addr_match:** per-entry valid/address compare with youngest-hit priority encode relative to wr_ptr. Outputs hit and hit_idx.

Test Plan:
- **Back-to-back writes, no grant:** ram_wr_gnt=0, 4 writes (addr 0x010..0x013, data 0xA0..0xA3) → buf_count=4, in_wr_ready=0 on the 5th. Then raise gnt → ram_we on 4 consecutive cycles in FIFO order; count reaches 0.
- **Forwarding:** with RAM_WR_FWD_EN and gnt=0, write 0x020←0x11 then 0x020←0x22, read 0x020 → rd_valid next cycle, rd_data=0x22.
- **Stall without forwarding:** no macro, same stimulus → in_rd_ready=0 until both entries drain after gnt=1. The read then returns 0x22 from the RAM.
- **Flush:** 3 entries buffered, gnt=1, flush_req → in_wr_ready=0 for 3 drain cycles; flush_done pulses 1 cycle after the last pop; NORMAL resumes.
- **Reset mid-operation:** 2 entries buffered, rst asserted → buf_count=0 immediately, ram_we=0, and those addresses are never written.
- **Simultaneous push and pop at count=2 with gnt=1** → count stays 2. A read of the popping head's address returns the buffered data (forward) or stalls (no macro).

Source files
------------

// File: rtl/ram_buf_pkg.sv
// Shared types for the posted-write buffer in front of the dual-port RAM.
package ram_buf_pkg;

    // Default geometry; the entry struct is sized from these.
    localparam int unsigned RAM_BUF_AW    = 12;
    localparam int unsigned RAM_BUF_DW    = 64;
    localparam int unsigned RAM_BUF_DEPTH = 4;

    // Occupancy counter width: must hold 0..DEPTH inclusive.
    localparam int unsigned RAM_BUF_CNT_W = $clog2(RAM_BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        NORMAL,
        FLUSH,
        DONE
    } ram_buf_state_e;

    typedef struct packed {
        logic [RAM_BUF_AW-1:0] addr;
        logic [RAM_BUF_DW-1:0] data;
    } ram_buf_entry_t;

endpackage

// File: rtl/ram_buf_addr_match.sv
// Compares every valid buffer entry against a read address and reports the
// youngest matching entry, where age is measured backwards from wr_ptr.
module ram_buf_addr_match #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic [DEPTH-1:0]                 valid,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
    input  logic [$clog2(DEPTH)-1:0]         wr_ptr,
    input  logic [ADDR_WIDTH-1:0]            addr,
    output logic                             hit,
    output logic [$clog2(DEPTH)-1:0]         hit_idx
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from the most recently written slot towards the oldest; first hit wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = wr_ptr - PTR_W'(k + 1);
            if (!hit && valid[idx] && (entry_addr[idx] == addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/ram_wr_post_buf.sv
// Write-posting front end for the dual-port RAM. Host writes are queued in a
// small FIFO and drained whenever the RAM write port is granted; host reads go
// straight to the RAM read port. Optional macro RAM_WR_FWD_EN: when defined,
// reads that hit a posted write are forwarded from the buffer; when undefined,
// such reads stall until the matching entries have drained.
module ram_wr_post_buf
    import ram_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_BUF_DW,
    parameter int unsigned ADDR_WIDTH = RAM_BUF_AW,
    parameter int unsigned DEPTH      = RAM_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_wr_valid,
    output logic                     in_wr_ready,
    input  logic [ADDR_WIDTH-1:0]    in_wr_addr,
    input  logic [DATA_WIDTH-1:0]    in_wr_data,
    input  logic                     in_rd_req,
    output logic                     in_rd_ready,
    input  logic [ADDR_WIDTH-1:0]    in_rd_addr,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     ram_we,
    input  logic                     ram_wr_gnt,
    output logic [ADDR_WIDTH-1:0]    ram_waddr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_re,
    output logic [ADDR_WIDTH-1:0]    ram_raddr,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    ram_buf_entry_t   mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    ram_buf_state_e   state_q, state_d;
    logic             rd_valid_q;

    logic                            push, pop;
    logic [DEPTH-1:0]                entry_valid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;
    logic                            hit;
    logic [PTR_W-1:0]                hit_idx;

    assign in_wr_ready = (count_q < FULL_COUNT) && (state_q == NORMAL);
    assign push        = in_wr_valid && in_wr_ready;
    assign ram_we      = (count_q != '0) && ram_wr_gnt;
    assign pop         = ram_we;
    assign ram_waddr   = mem_q[rd_ptr_q].addr;
    assign ram_wdata   = mem_q[rd_ptr_q].data;
    assign buf_count   = count_q;
    assign rd_valid    = rd_valid_q;

    // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Entry i is live when its distance from the head is below the occupancy.
    // The popping head stays live for the search because the RAM is read-old.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_valid[i] = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
            entry_addr[i]  = mem_q[i].addr;
        end
    end

    ram_buf_addr_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_match (
        .valid      (entry_valid),
        .entry_addr (entry_addr),
        .wr_ptr     (wr_ptr_q),
        .addr       (in_rd_addr),
        .hit        (hit),
        .hit_idx    (hit_idx)
    );

    assign ram_re    = in_rd_req && in_rd_ready;
    assign ram_raddr = ram_re ? in_rd_addr : '0;

`ifdef RAM_WR_FWD_EN
    logic                  fwd_hit_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    assign in_rd_ready = 1'b1;
    assign rd_data     = !rd_valid_q ? '0 : (fwd_hit_q ? fwd_data_q : ram_rdata);

    // Capture the youngest buffered value at read accept, before any same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q <= ram_re && hit;
            if (ram_re && hit) begin
                fwd_data_q <= mem_q[hit_idx].data;
            end
        end
    end
`else
    logic unused_hit_idx;

    assign in_rd_ready    = !hit;
    assign rd_data        = rd_valid_q ? ram_rdata : '0;
    assign unused_hit_idx = ^hit_idx;
`endif

    // FIFO storage, pointers, occupancy and read-valid pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{addr: in_wr_addr, data: in_wr_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            rd_valid_q <= ram_re;
        end
    end

    // Flush state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush sequencing: leave FLUSH once the buffer is (or is about to be) empty.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        unique case (state_q)
            NORMAL: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

endmodule
